// File: rtl/sys_ctrl_pkg.sv
// Shared state encoding and command codes for the REF_CLK command sequencer.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_TX,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_LSB,
    TX_MSB
  } state_t;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int DEF_OPA_ADDR = 0;
  localparam int DEF_OPB_ADDR = 1;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART RX frames into register-file accesses and
// ALU operations, then streams read data / ALU results into the TX FIFO.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int OPA_ADDR   = DEF_OPA_ADDR,
  parameter int OPB_ADDR   = DEF_OPB_ADDR
) (
  input  logic                    REF_CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_valid,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  input  logic                    fifo_full,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    rf_rd_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_valid
);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   rd_q, rd_n;
  logic [2*DATA_WIDTH-1:0] res_q, res_n;
  logic [ADDR_WIDTH-1:0]   rf_addr_n;
  logic [DATA_WIDTH-1:0]   rf_wr_data_n;
  logic [FUN_WIDTH-1:0]    alu_fun_n;
  logic                    rf_wr_en_n, rf_rd_en_n, alu_en_n, clk_gate_en_n;
  logic                    tx_state;

  assign tx_state   = (state == RD_TX) || (state == TX_LSB) || (state == TX_MSB);
  assign tx_d_valid = tx_state && !fifo_full;

  always_comb begin
    tx_p_data = '0;
    case (state)
      RD_TX:   tx_p_data = rd_q;
      TX_LSB:  tx_p_data = res_q[DATA_WIDTH-1:0];
      TX_MSB:  tx_p_data = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
      default: tx_p_data = '0;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_fun     <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      rd_q        <= rd_n;
      res_q       <= res_n;
      rf_addr     <= rf_addr_n;
      rf_wr_data  <= rf_wr_data_n;
      alu_fun     <= alu_fun_n;
      rf_wr_en    <= rf_wr_en_n;
      rf_rd_en    <= rf_rd_en_n;
      alu_en      <= alu_en_n;
      clk_gate_en <= clk_gate_en_n;
    end
  end

  // Strobes default low so every access is a single-cycle registered pulse.
  always_comb begin
    state_n       = state;
    addr_n        = addr_q;
    rd_n          = rd_q;
    res_n         = res_q;
    rf_addr_n     = rf_addr;
    rf_wr_data_n  = rf_wr_data;
    alu_fun_n     = alu_fun;
    rf_wr_en_n    = 1'b0;
    rf_rd_en_n    = 1'b0;
    alu_en_n      = 1'b0;
    clk_gate_en_n = clk_gate_en;
    case (state)
      IDLE: begin
        if (rx_d_valid) begin
          if (rx_p_data == DATA_WIDTH'(CMD_WR)) begin
            state_n = WR_ADDR;
          end else if (rx_p_data == DATA_WIDTH'(CMD_RD)) begin
            state_n = RD_ADDR;
          end else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_n       = OPA;
            clk_gate_en_n = 1'b1;
          end else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_n       = FUN;
            clk_gate_en_n = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (rx_d_valid) begin
          addr_n  = rx_p_data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_d_valid) begin
          rf_wr_en_n   = 1'b1;
          rf_addr_n    = addr_q;
          rf_wr_data_n = rx_p_data;
          state_n      = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_d_valid) begin
          rf_rd_en_n = 1'b1;
          rf_addr_n  = rx_p_data[ADDR_WIDTH-1:0];
          state_n    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid) begin
          rd_n    = rf_rd_data;
          state_n = RD_TX;
        end
      end
      RD_TX: begin
        if (tx_d_valid) state_n = IDLE;
      end
      OPA: begin
        if (rx_d_valid) begin
          rf_wr_en_n   = 1'b1;
          rf_addr_n    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_n = rx_p_data;
          state_n      = OPB;
        end
      end
      OPB: begin
        if (rx_d_valid) begin
          rf_wr_en_n   = 1'b1;
          rf_addr_n    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_n = rx_p_data;
          state_n      = FUN;
        end
      end
      FUN: begin
        if (rx_d_valid) begin
          alu_fun_n = rx_p_data[FUN_WIDTH-1:0];
          alu_en_n  = 1'b1;
          state_n   = ALU_WAIT;
        end
      end
      // The gate closes as the result is captured, so it is low in TX_LSB.
      ALU_WAIT: begin
        if (alu_out_valid) begin
          res_n         = alu_out;
          clk_gate_en_n = 1'b0;
          state_n       = TX_LSB;
        end
      end
      TX_LSB: begin
        if (tx_d_valid) state_n = TX_MSB;
      end
      TX_MSB: begin
        if (tx_d_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: table-driven frames with register-file
// and ALU response models, plus FIFO-stall and mid-frame reset sequences.
module tb_sys_cmd_ctrl;
  import sys_ctrl_pkg::*;

  logic        REF_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_valid = 1'b0;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic        clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_valid;

  sys_cmd_ctrl dut (
    .REF_CLK(REF_CLK), .RST(RST),
    .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .fifo_full(fifo_full),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .alu_fun(alu_fun), .alu_en(alu_en),
    .clk_gate_en(clk_gate_en), .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid)
  );

  always #5 REF_CLK = ~REF_CLK;

  typedef struct {
    logic [63:0] name;
    int          nbytes;
    logic [31:0] bytes;
    logic [15:0] alu_ret;
    int          exp_wr;
    logic [3:0]  wa0;
    logic [7:0]  wd0;
    logic [3:0]  wa1;
    logic [7:0]  wd1;
    int          exp_rd;
    int          exp_alu;
    logic [3:0]  exp_fun;
    int          exp_tx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
  } vec_t;

  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem[16];
  logic [15:0] alu_ret = '0;
  int          rd_dly = 0;
  int          alu_dly = 0;
  logic [3:0]  rd_addr_m = '0;
  logic [11:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          rd_cnt = 0;
  int          alu_cnt = 0;
  logic [3:0]  fun_seen = '0;
  int          overlap_cnt = 0;
  int          gate_bad = 0;

  // Register file and ALU models answer two cycles after their strobe.
  always @(posedge REF_CLK) begin
    #1;
    rf_rd_valid   = 1'b0;
    alu_out_valid = 1'b0;
    if (rd_dly == 1) begin
      rf_rd_valid = 1'b1;
      rf_rd_data  = mem[rd_addr_m];
    end
    if (rd_dly > 0) rd_dly--;
    if (alu_dly == 1) begin
      alu_out_valid = 1'b1;
      alu_out       = alu_ret;
    end
    if (alu_dly > 0) alu_dly--;
    if (!RST && rf_wr_en) mem[rf_addr] = rf_wr_data;
    if (!RST && rf_rd_en) begin
      rd_dly    = 2;
      rd_addr_m = rf_addr;
    end
    if (!RST && alu_en) alu_dly = 2;
  end

  always @(negedge REF_CLK) begin
    if (!RST) begin
      if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
      if (rf_rd_en) rd_cnt++;
      if (alu_en) begin
        alu_cnt++;
        fun_seen = alu_fun;
      end
      if (tx_d_valid) tx_q.push_back(tx_p_data);
      if ((int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_d_valid)) > 1) overlap_cnt++;
      if ((dut.state inside {OPA, OPB, FUN, ALU_WAIT}) && !clk_gate_en) gate_bad++;
      if ((dut.state inside {IDLE, TX_LSB, TX_MSB}) && clk_gate_en) gate_bad++;
    end
  end

  task automatic checkEq(input string what, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", what, actual, expected);
    end
  endtask

  task automatic clearLogs();
    wr_q.delete();
    tx_q.delete();
    rd_cnt      = 0;
    alu_cnt     = 0;
    overlap_cnt = 0;
    gate_bad    = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge REF_CLK);
    #1;
    rx_p_data  = b;
    rx_d_valid = 1'b1;
    @(posedge REF_CLK);
    #1;
    rx_d_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] bs;
    bs      = v.bytes;
    alu_ret = v.alu_ret;
    for (int i = 0; i < v.nbytes; i++) sendByte(bs[8*i +: 8]);
    repeat (20) @(posedge REF_CLK);
    @(negedge REF_CLK);
  endtask

  task automatic checkOutput(input vec_t v);
    string n;
    n = $sformatf("%s", v.name);
    checkEq({n, " wr count"}, wr_q.size(), v.exp_wr);
    if (v.exp_wr > 0 && wr_q.size() > 0) checkEq({n, " wr0"}, wr_q[0], {v.wa0, v.wd0});
    if (v.exp_wr > 1 && wr_q.size() > 1) checkEq({n, " wr1"}, wr_q[1], {v.wa1, v.wd1});
    checkEq({n, " rd count"}, rd_cnt, v.exp_rd);
    checkEq({n, " alu count"}, alu_cnt, v.exp_alu);
    if (v.exp_alu > 0) checkEq({n, " alu_fun"}, fun_seen, v.exp_fun);
    checkEq({n, " tx count"}, tx_q.size(), v.exp_tx);
    if (v.exp_tx > 0 && tx_q.size() > 0) checkEq({n, " tx0"}, tx_q[0], v.tx0);
    if (v.exp_tx > 1 && tx_q.size() > 1) checkEq({n, " tx1"}, tx_q[1], v.tx1);
    checkEq({n, " strobe overlap"}, overlap_cnt, 0);
    checkEq({n, " clk gate"}, gate_bad, 0);
    checkEq({n, " back in IDLE"}, dut.state, IDLE);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    // bytes: first frame byte in the low byte
    vecs[0] = '{"WR",      3, 32'h003C05AA, 16'h0000, 1, 4'h5, 8'h3C, 4'h0, 8'h00, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    vecs[1] = '{"RD",      2, 32'h000005BB, 16'h0000, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 0, 4'h0, 1, 8'h3C, 8'h00};
    vecs[2] = '{"ALUOP",   4, 32'h02100FCC, 16'h1234, 2, 4'h0, 8'h0F, 4'h1, 8'h10, 0, 1, 4'h2, 2, 8'h34, 8'h12};
    vecs[3] = '{"ILLEGAL", 1, 32'h00000055, 16'h0000, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    vecs[4] = '{"ALUNOP",  2, 32'h000007DD, 16'hABCD, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 1, 4'h7, 2, 8'hCD, 8'hAB};
    vecs[5] = '{"WRMASK",  3, 32'h00991FAA, 16'h0000, 1, 4'hF, 8'h99, 4'h0, 8'h00, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    vecs[6] = '{"RDHI",    2, 32'h00000FBB, 16'h0000, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 0, 4'h0, 1, 8'h99, 8'h00};

    repeat (3) @(posedge REF_CLK);
    #1;
    RST = 1'b0;
    @(negedge REF_CLK);
    checkEq("reset state", dut.state, IDLE);
    checkEq("reset rf_addr", rf_addr, 0);
    checkEq("reset rf_wr_en", rf_wr_en, 0);
    checkEq("reset rf_rd_en", rf_rd_en, 0);
    checkEq("reset alu_en", alu_en, 0);
    checkEq("reset clk_gate_en", clk_gate_en, 0);
    checkEq("reset tx_d_valid", tx_d_valid, 0);
    checkEq("reset tx_p_data", tx_p_data, 0);

    for (int i = 0; i < 7; i++) begin
      clearLogs();
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // ALU_NOP with the FIFO full: result must wait in TX_LSB, held stable.
    clearLogs();
    @(posedge REF_CLK);
    #1;
    fifo_full = 1'b1;
    alu_ret   = 16'h1234;
    sendByte(8'hDD);
    sendByte(8'h03);
    n = 0;
    while (!alu_out_valid && n < 20) begin
      @(posedge REF_CLK);
      #2;
      n++;
    end
    checkEq("stall alu result arrived", (n < 20), 1);
    repeat (10) @(negedge REF_CLK);
    checkEq("stall tx count", tx_q.size(), 0);
    checkEq("stall tx_d_valid", tx_d_valid, 0);
    checkEq("stall tx_p_data held", tx_p_data, 8'h34);
    checkEq("stall state", dut.state, TX_LSB);
    checkEq("stall alu_fun", alu_fun, 4'h3);
    checkEq("stall clk_gate_en", clk_gate_en, 0);
    @(posedge REF_CLK);
    #1;
    fifo_full = 1'b0;
    repeat (6) @(posedge REF_CLK);
    @(negedge REF_CLK);
    checkEq("drain tx count", tx_q.size(), 2);
    if (tx_q.size() > 1) begin
      checkEq("drain tx0", tx_q[0], 8'h34);
      checkEq("drain tx1", tx_q[1], 8'h12);
    end
    checkEq("drain state", dut.state, IDLE);
    checkEq("drain alu count", alu_cnt, 1);
    checkEq("drain overlap", overlap_cnt, 0);
    checkEq("drain clk gate", gate_bad, 0);

    // Reset mid-frame abandons the write; the data byte then lands in IDLE.
    clearLogs();
    sendByte(8'hAA);
    sendByte(8'h05);
    @(posedge REF_CLK);
    #1;
    RST = 1'b1;
    @(posedge REF_CLK);
    #1;
    RST = 1'b0;
    sendByte(8'h3C);
    repeat (5) @(posedge REF_CLK);
    @(negedge REF_CLK);
    checkEq("midreset wr count", wr_q.size(), 0);
    checkEq("midreset state", dut.state, IDLE);
    checkEq("midreset rf_addr", rf_addr, 0);
    checkEq("midreset rf_wr_data", rf_wr_data, 0);
    checkEq("midreset alu_fun", alu_fun, 0);
    checkEq("midreset rf_wr_en", rf_wr_en, 0);
    checkEq("midreset tx_p_data", tx_p_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
